// File: rtl/edge_frame_vga_transmitter.sv
// Rebuilds a VGA stream from tagged Sobel edge pixels through a two-row ping-pong line buffer.
// Optional macro EDGE_TX_THRESHOLD_EN binarizes the displayed pixel against P_THRESHOLD.
module edge_frame_vga_transmitter #(
   parameter int P_FRAME_COLUMNS     = 640,
   parameter int P_FRAME_ROWS        = 480,
   parameter int P_SUBPIXEL_DEPTH    = 8,
   parameter int P_H_FRONT_PORCH     = 16,
   parameter int P_H_SYNC            = 96,
   parameter int P_H_BACK_PORCH      = 48,
   parameter int P_V_FRONT_PORCH     = 10,
   parameter int P_V_SYNC            = 2,
   parameter int P_V_BACK_PORCH      = 33,
   parameter int P_THRESHOLD         = 128,
   parameter int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
   parameter int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS)
) (
   input  logic                            I_CLK,
   input  logic                            I_RESET_N,
   input  logic                            I_PIXEL_TICK,
   input  logic                            I_PIXEL_VALID,
   input  logic [P_FRAME_COLUMN_BITS-1:0]  I_COLUMN,
   input  logic [P_FRAME_ROW_BITS-1:0]     I_ROW,
   input  logic [P_SUBPIXEL_DEPTH-1:0]     I_PIXEL,
   output logic                            O_HSYNC,
   output logic                            O_VSYNC,
   output logic                            O_DATA_VALID,
   output logic [3*P_SUBPIXEL_DEPTH-1:0]   O_PIXEL,
   output logic [P_FRAME_COLUMN_BITS-1:0]  O_COLUMN,
   output logic [P_FRAME_ROW_BITS-1:0]     O_ROW,
   output logic                            O_FRAME_START,
   output logic                            O_WRITE_DROP
);

   localparam int H_TOTAL = P_FRAME_COLUMNS + P_H_FRONT_PORCH + P_H_SYNC + P_H_BACK_PORCH;
   localparam int V_TOTAL = P_FRAME_ROWS + P_V_FRONT_PORCH + P_V_SYNC + P_V_BACK_PORCH;
   localparam int H_BITS  = $clog2(H_TOTAL);
   localparam int V_BITS  = $clog2(V_TOTAL);

   localparam logic [H_BITS-1:0] H_ACT      = H_BITS'(P_FRAME_COLUMNS);
   localparam logic [H_BITS-1:0] H_SYNC_BEG = H_BITS'(P_FRAME_COLUMNS + P_H_FRONT_PORCH);
   localparam logic [H_BITS-1:0] H_SYNC_END = H_BITS'(P_FRAME_COLUMNS + P_H_FRONT_PORCH + P_H_SYNC);
   localparam logic [H_BITS-1:0] H_LAST     = H_BITS'(H_TOTAL - 1);
   localparam logic [V_BITS-1:0] V_ACT      = V_BITS'(P_FRAME_ROWS);
   localparam logic [V_BITS-1:0] V_SYNC_BEG = V_BITS'(P_FRAME_ROWS + P_V_FRONT_PORCH);
   localparam logic [V_BITS-1:0] V_SYNC_END = V_BITS'(P_FRAME_ROWS + P_V_FRONT_PORCH + P_V_SYNC);
   localparam logic [V_BITS-1:0] V_LAST     = V_BITS'(V_TOTAL - 1);
   localparam logic [P_FRAME_ROW_BITS-1:0]  ROW_LAST  = P_FRAME_ROW_BITS'(P_FRAME_ROWS - 1);
   localparam logic [P_FRAME_COLUMN_BITS:0] COL_LIMIT = (P_FRAME_COLUMN_BITS + 1)'(P_FRAME_COLUMNS);

   logic [H_BITS-1:0]           h_cnt;
   logic [V_BITS-1:0]           v_cnt;
   logic [P_SUBPIXEL_DEPTH-1:0] line_mem [2][P_FRAME_COLUMNS];
   logic [P_FRAME_ROW_BITS-1:0] bank_tag [2];
   logic [1:0]                  bank_tag_vld;

   logic                        active;
   logic [P_FRAME_ROW_BITS-1:0] v_row;
   logic [P_FRAME_ROW_BITS-1:0] v_row_next;
   logic                        wr_accept;
   logic                        rd_bank;
   logic [P_SUBPIXEL_DEPTH-1:0] rd_pixel;
   logic [P_SUBPIXEL_DEPTH-1:0] gray;
   logic                        pixel_on;

   always_ff @(posedge I_CLK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (I_PIXEL_TICK) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_BITS'(1);
         end else begin
            h_cnt <= h_cnt + H_BITS'(1);
         end
      end
   end

   // Vertical blanking behaves like the last active row so row 0 can be preloaded.
   always_comb begin
      active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      v_row      = (v_cnt < V_ACT) ? v_cnt[P_FRAME_ROW_BITS-1:0] : ROW_LAST;
      v_row_next = (v_row == ROW_LAST) ? '0 : v_row + P_FRAME_ROW_BITS'(1);
      wr_accept  = I_PIXEL_VALID && ({1'b0, I_COLUMN} < COL_LIMIT) &&
                   ((I_ROW == v_row) || (I_ROW == v_row_next));
   end

   always_ff @(posedge I_CLK) begin
      if (wr_accept) begin
         line_mem[I_ROW[0]][I_COLUMN] <= I_PIXEL;
         bank_tag[I_ROW[0]]           <= I_ROW;
      end
   end

   always_ff @(posedge I_CLK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         bank_tag_vld <= '0;
      end else if (wr_accept) begin
         bank_tag_vld[I_ROW[0]] <= 1'b1;
      end
   end

   // Reads see the pre-write memory and tag, so a same-cycle write shows next frame.
   always_comb begin
      rd_bank  = v_cnt[0];
      rd_pixel = line_mem[rd_bank][h_cnt[P_FRAME_COLUMN_BITS-1:0]];
      pixel_on = active && bank_tag_vld[rd_bank] &&
                 (bank_tag[rd_bank] == v_cnt[P_FRAME_ROW_BITS-1:0]);
`ifdef EDGE_TX_THRESHOLD_EN
      gray = (rd_pixel >= P_SUBPIXEL_DEPTH'(P_THRESHOLD)) ? '1 : '0;
`else
      gray = rd_pixel;
`endif
   end

   always_ff @(posedge I_CLK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         O_HSYNC       <= 1'b1;
         O_VSYNC       <= 1'b1;
         O_DATA_VALID  <= 1'b0;
         O_PIXEL       <= '0;
         O_COLUMN      <= '0;
         O_ROW         <= '0;
         O_FRAME_START <= 1'b0;
         O_WRITE_DROP  <= 1'b0;
      end else begin
         O_WRITE_DROP <= I_PIXEL_VALID && !wr_accept;
         if (I_PIXEL_TICK) begin
            O_HSYNC       <= !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
            O_VSYNC       <= !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
            O_DATA_VALID  <= active;
            O_PIXEL       <= pixel_on ? {gray, gray, gray} : '0;
            O_COLUMN      <= active ? h_cnt[P_FRAME_COLUMN_BITS-1:0] : '0;
            O_ROW         <= active ? v_cnt[P_FRAME_ROW_BITS-1:0] : '0;
            O_FRAME_START <= (h_cnt == '0) && (v_cnt == '0);
         end
      end
   end

endmodule

// File: tb/tb_edge_frame_vga_transmitter.sv
// Scoreboard bench for edge_frame_vga_transmitter on an 8x4 frame (H_TOTAL=12, V_TOTAL=7).
module tb_edge_frame_vga_transmitter;

   localparam int C = 8, R = 4, HFP = 1, HS = 2, HBP = 1, VFP = 1, VS = 1, VBP = 1;
   localparam int HT = C + HFP + HS + HBP;
   localparam int VT = R + VFP + VS + VBP;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        dv;
      logic [23:0] pix;
      logic [2:0]  col;
      logic [1:0]  row;
      logic        fs;
      logic        drop;
   } out_t;

   localparam out_t RST_OUT = '{hs: 1'b1, vs: 1'b1, dv: 1'b0, pix: 24'h0, col: 3'h0,
                                row: 2'h0, fs: 1'b0, drop: 1'b0};

   logic        I_CLK = 1'b0;
   logic        I_RESET_N = 1'b0;
   logic        I_PIXEL_TICK = 1'b0;
   logic        I_PIXEL_VALID = 1'b0;
   logic [2:0]  I_COLUMN = '0;
   logic [1:0]  I_ROW = '0;
   logic [7:0]  I_PIXEL = '0;
   logic        O_HSYNC, O_VSYNC, O_DATA_VALID, O_FRAME_START, O_WRITE_DROP;
   logic [23:0] O_PIXEL;
   logic [2:0]  O_COLUMN;
   logic [1:0]  O_ROW;

   edge_frame_vga_transmitter #(
      .P_FRAME_COLUMNS(C), .P_FRAME_ROWS(R), .P_SUBPIXEL_DEPTH(8),
      .P_H_FRONT_PORCH(HFP), .P_H_SYNC(HS), .P_H_BACK_PORCH(HBP),
      .P_V_FRONT_PORCH(VFP), .P_V_SYNC(VS), .P_V_BACK_PORCH(VBP),
      .P_THRESHOLD(128), .P_FRAME_COLUMN_BITS(3), .P_FRAME_ROW_BITS(2)
   ) dut (
      .I_CLK(I_CLK), .I_RESET_N(I_RESET_N), .I_PIXEL_TICK(I_PIXEL_TICK),
      .I_PIXEL_VALID(I_PIXEL_VALID), .I_COLUMN(I_COLUMN), .I_ROW(I_ROW), .I_PIXEL(I_PIXEL),
      .O_HSYNC(O_HSYNC), .O_VSYNC(O_VSYNC), .O_DATA_VALID(O_DATA_VALID), .O_PIXEL(O_PIXEL),
      .O_COLUMN(O_COLUMN), .O_ROW(O_ROW), .O_FRAME_START(O_FRAME_START),
      .O_WRITE_DROP(O_WRITE_DROP)
   );

   always #5 I_CLK = ~I_CLK;

   int   checks = 0;
   int   failures = 0;
   int   mh = 0, mv = 0;
   logic [7:0] mmem [2][C];
   int   mtag [2];
   bit   mtv [2];
   out_t last_exp = RST_OUT;
   out_t exp_q [$];
   int   tick_cnt = 0;
   int   fs_ticks [$];

   function automatic out_t observed();
      return '{hs: O_HSYNC, vs: O_VSYNC, dv: O_DATA_VALID, pix: O_PIXEL, col: O_COLUMN,
               row: O_ROW, fs: O_FRAME_START, drop: O_WRITE_DROP};
   endfunction

   function automatic logic [7:0] shade(input logic [7:0] raw);
`ifdef EDGE_TX_THRESHOLD_EN
      return (raw >= 8'd128) ? 8'hFF : 8'h00;
`else
      return raw;
`endif
   endfunction

   // One clock: drive inputs, predict registered outputs from the model, then compare.
   task automatic step(input bit tick, input bit vld, input int row, input int col,
                       input logic [7:0] pix);
      out_t e, o;
      int veff, vnext, b;
      bit acc, act, on;
      logic [7:0] g;
      @(negedge I_CLK);
      I_PIXEL_TICK  = tick;
      I_PIXEL_VALID = vld;
      I_ROW         = 2'(row);
      I_COLUMN      = 3'(col);
      I_PIXEL       = pix;
      e     = last_exp;
      veff  = (mv < R) ? mv : R - 1;
      vnext = (veff + 1) % R;
      acc   = (row == veff || row == vnext) && col < C;
      e.drop = vld && !acc;
      if (tick) begin
         act   = (mh < C) && (mv < R);
         b     = mv % 2;
         on    = act && mtv[b] && (mtag[b] == mv);
         g     = on ? shade(mmem[b][mh]) : 8'h00;
         e.hs  = !(mh >= C + HFP && mh < C + HFP + HS);
         e.vs  = !(mv >= R + VFP && mv < R + VFP + VS);
         e.dv  = act;
         e.pix = on ? {g, g, g} : 24'h0;
         e.col = act ? 3'(mh) : 3'd0;
         e.row = act ? 2'(mv) : 2'd0;
         e.fs  = (mh == 0) && (mv == 0);
         mh = mh + 1;
         if (mh == HT) begin
            mh = 0;
            mv = (mv + 1) % VT;
         end
         tick_cnt++;
      end
      if (vld && acc) begin
         mmem[row % 2][col] = pix;
         mtag[row % 2] = row;
         mtv[row % 2] = 1'b1;
      end
      exp_q.push_back(e);
      last_exp = e;
      @(posedge I_CLK);
      #1;
      o = observed();
      e = exp_q.pop_front();
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL out_word observed=%h expected=%h (ticks=%0d)", o, e, tick_cnt);
      end
      if (tick && o.fs) fs_ticks.push_back(tick_cnt);
      I_PIXEL_VALID = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 8'h00);
   endtask

   task automatic run_to(input int th, input int tv);
      int guard = 0;
      while (!(mh == th && mv == tv) && guard < 200) begin
         step(1'b1, 1'b0, 0, 0, 8'h00);
         guard++;
      end
      checks++;
      assert (guard < 200) else begin
         failures++;
         $error("FAIL run_to_bound observed=%0d expected=<200", guard);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      out_t o;
      o = observed();
      checks++;
      assert (o === RST_OUT) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, o, RST_OUT);
      end
   endtask

   initial begin
      logic [23:0] same_px;
      #12;
      check_reset_outputs("reset_state");
      @(negedge I_CLK);
      I_RESET_N = 1'b1;

      // Frame 0 blank, then into frame 1's vertical blanking.
      idle(84);
      run_to(0, 4);
      checks++;
      assert (fs_ticks.size() >= 2 && (fs_ticks[1] - fs_ticks[0]) === 84) else begin
         failures++;
         $error("FAIL frame_period observed=%0d expected=84",
                (fs_ticks.size() >= 2) ? fs_ticks[1] - fs_ticks[0] : -1);
      end

      // Preload row 0 in blanking; row 1 is rejected there, row 3 accepted.
      for (int c = 0; c < C; c++) step(1'b1, 1'b1, 0, c, 8'(8'h10 + c));
      step(1'b1, 1'b1, 1, 5, 8'h55);
      checks++;
      assert (O_WRITE_DROP === 1'b1) else begin
         failures++;
         $error("FAIL drop_in_blank observed=%b expected=1", O_WRITE_DROP);
      end
      step(1'b1, 1'b1, 3, 2, 8'h33);

      // Frame 2 row 0: fill row 1, try row 3, and hold outputs over non-tick cycles.
      run_to(0, 0);
      for (int c = 0; c < C; c++) begin
         logic [7:0] px;
         px = (c == 5) ? 8'h55 : (c == 6) ? 8'd127 : (c == 7) ? 8'd128 : 8'(8'h20 + c);
         step(1'b1, 1'b1, 1, c, px);
      end
      step(1'b1, 1'b1, 3, 1, 8'h99);
      checks++;
      assert (O_WRITE_DROP === 1'b1) else begin
         failures++;
         $error("FAIL drop_row3 observed=%b expected=1", O_WRITE_DROP);
      end
      step(1'b0, 1'b0, 0, 0, 8'h00);
      step(1'b0, 1'b1, 2, 0, 8'h44);
      step(1'b0, 1'b0, 0, 0, 8'h00);

      // Same-cycle write and read of (5,1).
      run_to(5, 1);
      step(1'b1, 1'b1, 1, 5, 8'hAA);
`ifdef EDGE_TX_THRESHOLD_EN
      same_px = 24'h000000;
`else
      same_px = 24'h555555;
`endif
      checks++;
      assert (O_PIXEL === same_px) else begin
         failures++;
         $error("FAIL same_cycle_read observed=%h expected=%h", O_PIXEL, same_px);
      end
      run_to(5, 1);
      step(1'b1, 1'b0, 0, 0, 8'h00);
`ifdef EDGE_TX_THRESHOLD_EN
      same_px = 24'hFFFFFF;
`else
      same_px = 24'hAAAAAA;
`endif
      checks++;
      assert (O_PIXEL === same_px) else begin
         failures++;
         $error("FAIL next_frame_read observed=%h expected=%h", O_PIXEL, same_px);
      end

      // Mid-frame asynchronous reset at (4,2).
      run_to(4, 2);
      @(negedge I_CLK);
      I_PIXEL_TICK = 1'b0;
      I_RESET_N = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      mh = 0;
      mv = 0;
      mtv[0] = 1'b0;
      mtv[1] = 1'b0;
      last_exp = RST_OUT;
      @(posedge I_CLK);
      #1;
      check_reset_outputs("reset_hold");
      @(negedge I_CLK);
      I_RESET_N = 1'b1;
      fs_ticks.delete();
      idle(90);
      checks++;
      assert (fs_ticks.size() >= 1 && fs_ticks[0] === tick_cnt - 89) else begin
         failures++;
         $error("FAIL restart_frame_start observed=%0d expected=%0d",
                (fs_ticks.size() >= 1) ? fs_ticks[0] : -1, tick_cnt - 89);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/edge_frame_vga_transmitter.md
# edge_frame_vga_transmitter

Display-side counterpart of the grayscale matrix converter. It accepts edge-magnitude pixels from the Sobel stage (tagged with frame column/row), holds them in a two-row ping-pong line buffer, and regenerates a VGA stream with its own H/V timing counters, sync pulses, data-valid and 24-bit RGB (gray replicated). It sits at the tail of the edge detection pipeline, driving the VGA output pins.

## Interface
- P_FRAME_COLUMNS, 640, active columns per row
- P_FRAME_ROWS, 480, active rows per frame
- P_SUBPIXEL_DEPTH, 8, edge pixel width; output pixel is 3x this
- P_H_FRONT_PORCH / P_H_SYNC / P_H_BACK_PORCH, 16 / 96 / 48, horizontal blanking in ticks
- P_V_FRONT_PORCH / P_V_SYNC / P_V_BACK_PORCH, 10 / 2 / 33, vertical blanking in lines
- P_THRESHOLD, 128, binarization level (used only with the macro)
- P_FRAME_COLUMN_BITS / P_FRAME_ROW_BITS, $clog2 of columns / rows
- I_CLK  in  1  system clock; all state on rising edge
- I_RESET_N  in  1  reset, asynchronous, active-low
- I_PIXEL_TICK  in  1  pixel-rate enable; timing advances only on cycles where high
- I_PIXEL_VALID  in  1  write strobe for one edge pixel (one per cycle max)
- I_COLUMN  in  P_FRAME_COLUMN_BITS  column of incoming pixel
- I_ROW  in  P_FRAME_ROW_BITS  row of incoming pixel
- I_PIXEL  in  P_SUBPIXEL_DEPTH  edge magnitude
- O_HSYNC  out  1  horizontal sync, active-low
- O_VSYNC  out  1  vertical sync, active-low
- O_DATA_VALID  out  1  high during active region
- O_PIXEL  out  3*P_SUBPIXEL_DEPTH  {g,g,g}; zero outside active region
- O_COLUMN / O_ROW  out  column/row bits  coordinate of the current O_PIXEL
- O_FRAME_START  out  1  one-cycle pulse with first active pixel (0,0)
- O_WRITE_DROP  out  1  one-cycle pulse when a write is rejected

## Operation
- Counters h (0..H_TOTAL-1), v (0..V_TOTAL-1); H_TOTAL = COLUMNS+HFP+HSYNC+HBP, V likewise. h increments on tick; at H_TOTAL-1 wraps to 0 and v increments; v wraps at V_TOTAL-1.
- Active: h<COLUMNS and v<ROWS. HSYNC low for h in [COLUMNS+HFP, COLUMNS+HFP+HSYNC); VSYNC low for v in [ROWS+VFP, ROWS+VFP+VSYNC).
- Buffer: two banks of COLUMNS entries, bank select = row[0]. Each bank has tag (row) and tag-valid bit.
- Write accepted iff I_ROW == v or I_ROW == (v+1) mod ROWS, and I_COLUMN < COLUMNS; during vertical blanking v is treated as ROWS-1 (so row 0 accepted). Accepted write stores pixel, sets bank tag=I_ROW, tag-valid=1. Else O_WRITE_DROP pulses, no state change.
- Read for active (h,v): bank v[0] at h; if tag-valid and tag==v output {g,g,g}, else black (0).
- Same-cycle write and read of one address: read returns old data.
- Pixel datapath is unsigned; no arithmetic on pixel values.

## Timing
- Reset values: h=v=0, tags invalid, O_HSYNC=1, O_VSYNC=1, O_DATA_VALID=0, O_PIXEL=0, O_COLUMN=0, O_ROW=0, O_FRAME_START=0, O_WRITE_DROP=0.
- Outputs registered, updated only on tick cycles, from pre-increment counter values: latency one I_CLK cycle after the tick; held between ticks.
- First tick after reset emits (0,0) with O_DATA_VALID=1 and O_FRAME_START=1.
- O_WRITE_DROP asserted the cycle after the rejected strobe, independent of tick.
- Reset assertion mid-frame clears immediately (async); outputs return to reset values with no glitch pulse.
- Buffer contents not reset; only tag-valid cleared.

## Configuration
- EDGE_TX_THRESHOLD_EN defined: displayed g = all-ones if stored pixel >= P_THRESHOLD, else 0 (black stays black for invalid tags).
- Undefined: g = stored pixel unchanged; P_THRESHOLD ignored.

## Test plan
All with COLUMNS=8, ROWS=4, H porch/sync/back 1/2/1 (H_TOTAL=12), V 1/1/1 (V_TOTAL=7), tick every cycle.
- Reset release, no writes -> O_FRAME_START at first tick output, 8 valid black pixels per line, HSYNC low for h=9,10, VSYNC low for v=5, period 84 ticks.
- Write row 0 cols 0..7 = 0x10..0x17 during vertical blanking -> next frame row 0 outputs 0x101010..0x171717, row 1 black.
- Write I_ROW=3 while v=0 -> O_WRITE_DROP pulse next cycle; row 3 later shows black.
- Write (5,v) value 0xAA same cycle as read of (5,v) holding 0x55 -> output 0x555555; next frame 0xAAAAAA if tag still valid.
- Assert I_RESET_N low at h=4,v=2 -> outputs immediately reset values; restart at (0,0) with O_FRAME_START.
- With EDGE_TX_THRESHOLD_EN, pixels 127 and 128 -> outputs 0x000000 and 0xFFFFFF.
